// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Pipelined W-bit log shifter: logical left, logical right, arithmetic
//   right and rotate right. The SAW log layers (shift by 2^j when amt bit j
//   is set) are spread over STAGES register stages, with layer j placed in
//   stage floor(j*STAGES/SAW). The pipeline is elastic: valid/ready on both
//   sides, and each stage loads when it is empty or its contents move on.
//   Latency is STAGES cycles and throughput is one item per cycle.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    request handshake
//   in_data, in_amt      operand and shift amount (0..W-1)
//   in_op                00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_tag               sideband, returned unmodified with the result
//   out_valid/out_ready  result handshake
//   out_data             shifted result
//   out_cout             last bit shifted out (0 when the amount is 0)
//   out_zero             out_data == 0
//   out_tag              tag of this result
module pipelined_barrel_shifter #(
  parameter int W      = 32,
  parameter int SAW    = $clog2(W),
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [SAW-1:0]  in_amt,
  input  logic [1:0]      in_op,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_cout,
  output logic            out_zero,
  output logic [TAGW-1:0] out_tag
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  typedef struct packed {
    logic [W-1:0]    data;
    logic [SAW-1:0]  amt;
    logic [1:0]      op;
    logic [TAGW-1:0] tag;
    logic            cout;
  } item_t;

  item_t             st  [STAGES];
  item_t             src [STAGES];
  item_t             nxt [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] rdy;
  logic              zero_q;
  logic              nxt_zero;

  // Applies every log layer that belongs to stage k. The carry is tracked
  // per layer: the last bit leaving on layer j is the lowest (left shift)
  // or highest (right shift) of the 2^j bits dropped, and the highest
  // active layer ends up owning out_cout. Rotates drop nothing, so their
  // carry is taken from the final result instead.
  function automatic item_t apply_layers(input item_t it, input int k);
    item_t r;
    int    sh;
    r = it;
    for (int j = 0; j < SAW; j++) begin
      sh = 1 << j;
      if (((j * STAGES) / SAW) == k && it.amt[j]) begin
        case (r.op)
          OP_LSL: begin
            r.cout = r.data[W-sh];
            r.data = r.data << sh;
          end
          OP_LSR: begin
            r.cout = r.data[sh-1];
            r.data = r.data >> sh;
          end
          OP_ASR: begin
            r.cout = r.data[sh-1];
            r.data = W'($signed(r.data) >>> sh);
          end
          default: begin
            r.data = (r.data >> sh) | (r.data << (W - sh));
          end
        endcase
      end
    end
    return r;
  endfunction

  // A stage can take a new item unless it and every stage downstream of it
  // are full while the output is stalled. Written per stage from the valid
  // bits so the ready chain has no combinational self-dependency.
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign rdy[k] = out_ready || !(&vld[STAGES-1:k]);
  end

  always_comb begin
    src[0]     = '{data: in_data, amt: in_amt, op: in_op, tag: in_tag, cout: 1'b0};
    src_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src[k]     = st[k-1];
      src_vld[k] = vld[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      nxt[k] = apply_layers(src[k], k);
    end
    if (nxt[STAGES-1].op == 2'b11 && nxt[STAGES-1].amt != '0) begin
      nxt[STAGES-1].cout = nxt[STAGES-1].data[W-1];
    end
    nxt_zero = (nxt[STAGES-1].data == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        st[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= src_vld[k];
          // Payload only moves with a real item, so a drained stage keeps
          // its last contents rather than picking up garbage.
          if (src_vld[k]) begin
            st[k] <= nxt[k];
          end
        end
      end
      if (rdy[STAGES-1] && src_vld[STAGES-1]) begin
        zero_q <= nxt_zero;
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign out_data  = st[STAGES-1].data;
  assign out_cout  = st[STAGES-1].cout;
  assign out_tag   = st[STAGES-1].tag;
  assign out_zero  = zero_q;

endmodule
